// File: rtl/memory_param.sv
// ---------------------------------------------------------------------------
// memory_param
//
// Single-port word memory. After reset it runs a self-clearing sweep that
// writes zero to every location, then serves one read or write request per
// clock. Reads have one cycle of latency: the word appears on 'out' and
// 'out_valid' pulses for exactly one cycle.
//
// Optional feature macro: MEM_BYTE_WR_EN
//   defined   -> writes update only the byte lanes with be[i]=1
//   undefined -> be is ignored and every write updates the full word
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width, DEPTH = 2**ADDR_W words
//   BE_W    number of byte lanes (DATA_W/8)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset, restarts the clear sweep
//   req        access request
//   wr_en      1 = write, 0 = read (qualifies req)
//   addr       word address
//   in         write data
//   be         byte-lane write enables, bit i covers in[8i+7:8i]
//   ready      high when a request can be accepted (req && ready accepts)
//   out        registered read data, holds between reads
//   out_valid  one-cycle pulse marking new read data on out
//   busy       high while the clear sweep runs
// ---------------------------------------------------------------------------
module memory_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in,
    input  logic [BE_W-1:0]   be,
    output logic              ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept_rd;
    logic accept_wr;

    // ready is only high in IDLE, so these already exclude the sweep
    assign accept_rd = req && ready && !wr_en;
    assign accept_wr = req && ready && wr_en;

    // Control FSM with registered busy/ready and the read data path.
    // busy and ready are updated together with the state so they are
    // always glitch-free registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            ready     <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    // Leave on the edge that clears the last location
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept_rd) begin
                        out       <= mem[addr];
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array has no reset; the sweep provides the zero contents.
    // While rst is held the FSM sits in CLEAR with clr_cnt=0, so the only
    // effect is location 0 being rewritten with zero.
`ifdef MEM_BYTE_WR_EN
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= in[8*i +: 8];
                end
            end
        end
    end
`else
    // be stays on the port list for a uniform interface but has no effect
    logic unused_be;
    assign unused_be = ^be;

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept_wr) begin
            mem[addr] <= in;
        end
    end
`endif

endmodule

// File: tb/tb_memory_param.sv
// ---------------------------------------------------------------------------
// tb_memory_param
//
// Scoreboard bench for memory_param with DATA_W=16, ADDR_W=4 (16 words).
// Accepted reads push their hand-computed expected word and acceptance cycle
// into a queue; an independent monitor pops and compares whenever out_valid
// is seen. Byte-lane expectations follow MEM_BYTE_WR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_memory_param;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int BE_W   = 2;

    logic              clk;
    logic              rst;
    logic              req;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              out_valid;
    logic              busy;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t sb [$];
    int   cyc;
    int   n_checks;
    int   n_fails;

    memory_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr_en     (wr_en),
        .addr      (addr),
        .in        (wdata),
        .be        (be),
        .ready     (ready),
        .out       (rdata),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time-stamp accepted reads
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports failures
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding read,
    // both in data and in arriving exactly one cycle after acceptance
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out_valid", {16'h0, rdata}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("read_data", {16'h0, rdata}, {16'h0, e.data});
                checkOutput("read_latency", cyc, e.cyc);
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One request per call; reads push their expected word after acceptance
    task automatic applyStimulus(input logic is_wr, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b,
                                 input logic [DATA_W-1:0] expected);
        exp_t e;
        req   = 1'b1;
        wr_en = is_wr;
        addr  = a;
        wdata = d;
        be    = b;
        stepCycle();
        if (!is_wr) begin
            e.data = expected;
            e.cyc  = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idleCycles(input int n);
        req   = 1'b0;
        wr_en = 1'b0;
        repeat (n) stepCycle();
    endtask

    // Assert reset mid-cycle, check async effect, then time the sweep.
    // With inject_at >= 0 a write to addr 0 is presented on that sweep
    // cycle and a read of addr 7 on the next; both must be ignored.
    task automatic doReset(input int inject_at);
        int n;
        rst = 1'b1;
        req = 1'b0;
        sb.delete();
        #1;
        checkOutput("rst_busy", {31'h0, busy}, 32'h1);
        checkOutput("rst_ready", {31'h0, ready}, 32'h0);
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_out", {16'h0, rdata}, 32'h0);
        stepCycle();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (inject_at >= 0 && n == inject_at) begin
                req   = 1'b1;
                wr_en = 1'b1;
                addr  = '0;
                wdata = 16'h5555;
                be    = 2'b11;
                checkOutput("sweep_ready_low", {31'h0, ready}, 32'h0);
            end else if (inject_at >= 0 && n == inject_at + 1) begin
                wr_en = 1'b0;
                addr  = 4'd7;
            end else if (inject_at >= 0 && n == inject_at + 2) begin
                req = 1'b0;
            end
            stepCycle();
            n++;
        end
        req = 1'b0;
        checkOutput("sweep_cycles", n, 16);
        checkOutput("ready_after_sweep", {31'h0, ready}, 32'h1);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_lane;

        n_checks = 0;
        n_fails  = 0;
        rst   = 1'b0;
        req   = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        stepCycle();
        stepCycle();

        // Reset sweep, then every address reads back zero
        doReset(-1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, ADDR_W'(i), 16'h0, 2'b00, 16'h0000);
        end
        idleCycles(2);

        // Full write, read back next cycle
        applyStimulus(1'b1, 4'd5, 16'h1234, 2'b11, 16'h0);
        applyStimulus(1'b0, 4'd5, 16'h0, 2'b00, 16'h1234);

        // Partial-lane write; out must hold and out_valid must stay low
`ifdef MEM_BYTE_WR_EN
        exp_lane = 16'h12CD;
`else
        exp_lane = 16'hABCD;
`endif
        applyStimulus(1'b1, 4'd5, 16'hABCD, 2'b01, 16'h0);
        checkOutput("write_no_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("write_holds_out", {16'h0, rdata}, 32'h1234);
        applyStimulus(1'b0, 4'd5, 16'h0, 2'b00, exp_lane);
        idleCycles(2);

        // Back-to-back writes then back-to-back reads
        applyStimulus(1'b1, 4'd1, 16'h0004, 2'b11, 16'h0);
        applyStimulus(1'b1, 4'd2, 16'h0015, 2'b11, 16'h0);
        applyStimulus(1'b1, 4'd3, 16'h0016, 2'b11, 16'h0);
        applyStimulus(1'b0, 4'd1, 16'h0, 2'b00, 16'h0004);
        applyStimulus(1'b0, 4'd2, 16'h0, 2'b00, 16'h0015);
        applyStimulus(1'b0, 4'd3, 16'h0, 2'b00, 16'h0016);
        idleCycles(2);

        // Requests during the sweep are ignored; sweep clears old data
        applyStimulus(1'b1, 4'd7, 16'hBEEF, 2'b11, 16'h0);
        idleCycles(1);
        doReset(2);
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 16'h0000);
        applyStimulus(1'b0, 4'd7, 16'h0, 2'b00, 16'h0000);
        applyStimulus(1'b0, 4'd3, 16'h0, 2'b00, 16'h0000);
        idleCycles(2);

        // Reset right after a read is accepted discards the result
        applyStimulus(1'b1, 4'd5, 16'h1234, 2'b11, 16'h0);
        applyStimulus(1'b0, 4'd5, 16'h0, 2'b00, 16'h1234);
        checkOutput("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("pre_rst_out", {16'h0, rdata}, 32'h1234);
        doReset(-1);
        applyStimulus(1'b0, 4'd5, 16'h0, 2'b00, 16'h0000);
        idleCycles(3);

        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
